// File: rtl/async_queue_link_pkg.sv
// Shared types for the AsyncQueue local-end link controller.
package async_queue_link_pkg;

   typedef enum logic [2:0] {
      ANNOUNCE,
      ACTIVE,
      FLUSH,
      DRAIN,
      QUIESCED
   } link_state_t;

   localparam int ERR_TIMEOUT = 0;
   localparam int ERR_COUNT   = 1;

endpackage

// File: rtl/async_queue_valid_sync.sv
// Multi-flop synchronizer for the remote end's valid, cleared by the async reset.
module async_queue_valid_sync #(
   parameter int SYNC_STAGES = 3
) (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d};
      end
   end

   assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/async_queue_link_ctrl.sv
// Local-end link controller: valid handshake, enqueue gating, flush on remote loss,
// in-flight tracking and drain before quiesce.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ANNOUNCE | local_valid up, waiting for the remote end's valid
//   ACTIVE   | both ends valid, local enqueue permitted
//   FLUSH    | one cycle: remote lost, queue pointers reset, count cleared
//   DRAIN    | quiesce requested, waiting for in-flight beats to be acked
//   QUIESCED | drained, local_valid down until quiesce_req is released
module async_queue_link_ctrl
   import async_queue_link_pkg::*;
#(
   parameter int SYNC_STAGES = 3,
   parameter int CNT_W       = 4,
   parameter int TIMEOUT_CYC = 1024,
   parameter int TO_W        = 11
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             remote_valid,
   input  logic             quiesce_req,
   input  logic             inflight_inc,
   input  logic             inflight_dec,
   output logic             local_valid,
   output logic             queue_enable,
   output logic             queue_flush,
   output logic             quiesced,
   output logic [1:0]       err,
   output logic [CNT_W-1:0] inflight
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(TIMEOUT_CYC);

   link_state_t      state;
   link_state_t      state_nxt;
   logic             rv_s;
   logic             timer_run;
   logic             timer_tc;
   logic [TO_W-1:0]  to_left;
   logic [CNT_W-1:0] cnt_nxt;
   logic             cnt_err;

   async_queue_valid_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_valid_sync (
      .clock  (clock),
      .reset_n(reset_n),
      .d      (remote_valid),
      .q      (rv_s)
   );

   // Loss of the remote valid outranks everything else in ACTIVE and DRAIN.
   always_comb begin
      state_nxt = state;
      case (state)
         ANNOUNCE: if (rv_s) state_nxt = ACTIVE;
         ACTIVE: begin
            if (!rv_s)            state_nxt = FLUSH;
            else if (quiesce_req) state_nxt = DRAIN;
         end
         FLUSH: state_nxt = ANNOUNCE;
         DRAIN: begin
            if (!rv_s)                 state_nxt = FLUSH;
            else if (inflight == '0)   state_nxt = QUIESCED;
         end
         QUIESCED: if (!quiesce_req) state_nxt = ANNOUNCE;
         default: state_nxt = ANNOUNCE;
      endcase
   end

   always_comb begin
      cnt_nxt = inflight;
      cnt_err = 1'b0;
      if (inflight_inc && !queue_enable) begin
         cnt_err = 1'b1;
      end
      if (inflight_inc && !inflight_dec) begin
         if (inflight == CNT_MAX) cnt_err = 1'b1;
         else                     cnt_nxt = inflight + 1'b1;
      end else if (!inflight_inc && inflight_dec) begin
         if (inflight == '0) cnt_err = 1'b1;
         else                cnt_nxt = inflight - 1'b1;
      end
      if (state == FLUSH) begin
         cnt_nxt = '0;
      end
   end

   // Remaining-cycles timer; reloads on every state change, sticks at zero on expiry.
   assign timer_run = ((state == ANNOUNCE) || (state == DRAIN)) && (state_nxt == state);
   assign timer_tc  = timer_run && (to_left == TO_W'(1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         to_left <= TO_LOAD;
      end else if (state_nxt != state) begin
         to_left <= TO_LOAD;
      end else if (timer_run && (to_left != '0)) begin
         to_left <= to_left - 1'b1;
      end
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ANNOUNCE;
         local_valid  <= 1'b0;
         queue_enable <= 1'b0;
         queue_flush  <= 1'b0;
         quiesced     <= 1'b0;
         err          <= '0;
         inflight     <= '0;
      end else begin
         state        <= state_nxt;
         local_valid  <= (state_nxt != QUIESCED);
         queue_enable <= (state_nxt == ACTIVE);
         queue_flush  <= (state_nxt == FLUSH);
         quiesced     <= (state_nxt == QUIESCED);
         inflight     <= cnt_nxt;
         if (timer_tc) err[ERR_TIMEOUT] <= 1'b1;
         if (cnt_err)  err[ERR_COUNT]   <= 1'b1;
      end
   end

endmodule
